sobel_stream: RTL

Streaming, parametrised successor to the fixed 3x3-window `sobel` operator. It accepts a raster-order grey pixel stream, builds the 3x3 neighbourhood internally with two line buffers, and emits one |Gx|+|Gy| edge magnitude per interior pixel. An optional loop-perforation mode skips every second output column, enabling precise-vs-approximate comparisons in hardware instead of in the testbench. It sits between the image source (file reader or DMA) and the output writer.

---
 rtl/sobel_stream_if.sv | 25 ++
 rtl/sobel_stream.sv | 131 +++++++++++++
 2 files changed

// File: rtl/sobel_stream_if.sv
// Pixel stream bundle for sobel_stream: input beat plus perforation control, output beat.
interface sobel_stream_if #(
    parameter int unsigned PIX_W = 8
);
    logic             in_valid;
    logic             in_sof;
    logic [PIX_W-1:0] in_pixel;
    logic             perf_en;
    logic             out_valid;
    logic             out_sof;
    logic             out_eol;
    logic [PIX_W-1:0] out_pixel;

    // Operator side: consumes the input beat, produces the output beat.
    modport slave (
        input  in_valid, in_sof, in_pixel, perf_en,
        output out_valid, out_sof, out_eol, out_pixel
    );

    // Source/sink side.
    modport master (
        output in_valid, in_sof, in_pixel, perf_en,
        input  out_valid, out_sof, out_eol, out_pixel
    );
endinterface

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge magnitude with two line buffers and optional
// column perforation. Two-cycle latency from window-completing beat to output.
module sobel_stream #(
    parameter int unsigned IMG_W = 512,
    parameter int unsigned IMG_H = 512,
    parameter int unsigned PIX_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    sobel_stream_if.slave  bus
);
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned GW = PIX_W + 3;
    localparam logic [GW-1:0] MAX_PIX = GW'((2 ** PIX_W) - 1);

    logic [CW-1:0]    col, col_c;
    logic [RW-1:0]    row, row_c;
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] lb2 [IMG_W];
    logic [PIX_W-1:0] top_c, mid_c;
    logic [PIX_W-1:0] w0_top, w0_mid, w0_bot;
    logic [PIX_W-1:0] w1_top, w1_mid, w1_bot;
    logic             win_c;
    logic [GW-1:0]    gx_c, gy_c;
    logic             s1_valid, s1_sof, s1_eol, s1_hold;
    logic [GW-1:0]    s1_gx, s1_gy;
    logic [GW-1:0]    abs_gx_c, abs_gy_c, mag_c;

    // Position of the current beat; an in_sof beat is always (0,0).
    always_comb begin
        col_c = bus.in_sof ? '0 : col;
        row_c = bus.in_sof ? '0 : row;
    end

    // Raster position counters, advancing one step per accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (bus.in_valid) begin
            if (col_c == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= (row_c == RW'(IMG_H - 1)) ? '0 : row_c + RW'(1);
            end else begin
                col <= col_c + CW'(1);
                row <= row_c;
            end
        end
    end

    // Newest window column: rows r-2 and r-1 come from the line buffers.
    always_comb begin
        top_c = lb2[col_c];
        mid_c = lb1[col_c];
    end

    // Line buffers: row r-1 moves down into lb2 as row r replaces it in lb1.
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            lb1[col_c] <= bus.in_pixel;
            lb2[col_c] <= mid_c;
        end
    end

    // Two older window columns; data only, qualified by the pipeline valids.
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            w0_top <= w1_top;
            w0_mid <= w1_mid;
            w0_bot <= w1_bot;
            w1_top <= top_c;
            w1_mid <= mid_c;
            w1_bot <= bus.in_pixel;
        end
    end

    // Gradients over p0..p8 = {w0,w1,new} x {top,mid,bot}; GW bits never overflow.
    always_comb begin
        win_c = bus.in_valid && (row_c >= RW'(2)) && (col_c >= CW'(2));
        gx_c  = (GW'(top_c) + (GW'(mid_c) << 1) + GW'(bus.in_pixel))
              - (GW'(w0_top) + (GW'(w0_mid) << 1) + GW'(w0_bot));
        gy_c  = (GW'(w0_bot) + (GW'(w1_bot) << 1) + GW'(bus.in_pixel))
              - (GW'(w0_top) + (GW'(w1_top) << 1) + GW'(top_c));
    end

    // Stage 1: register gradients and frame markers; odd column k=c-2 has odd c.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_eol   <= 1'b0;
            s1_hold  <= 1'b0;
            s1_gx    <= '0;
            s1_gy    <= '0;
        end else begin
            s1_valid <= win_c;
            s1_sof   <= win_c && (row_c == RW'(2)) && (col_c == CW'(2));
            s1_eol   <= win_c && (col_c == CW'(IMG_W - 1));
            s1_hold  <= win_c && bus.perf_en && col_c[0];
            if (win_c) begin
                s1_gx <= gx_c;
                s1_gy <= gy_c;
            end
        end
    end

    // Magnitude |gx|+|gy| from the two's-complement gradients.
    always_comb begin
        abs_gx_c = s1_gx[GW-1] ? (GW'(0) - s1_gx) : s1_gx;
        abs_gy_c = s1_gy[GW-1] ? (GW'(0) - s1_gy) : s1_gy;
        mag_c    = abs_gx_c + abs_gy_c;
    end

    // Stage 2: saturate, or keep the previous value on a perforated column.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_sof   <= 1'b0;
            bus.out_eol   <= 1'b0;
            bus.out_pixel <= '0;
        end else begin
            bus.out_valid <= s1_valid;
            bus.out_sof   <= s1_sof;
            bus.out_eol   <= s1_eol;
            if (s1_valid && !s1_hold) begin
                bus.out_pixel <= (mag_c > MAX_PIX) ? MAX_PIX[PIX_W-1:0] : mag_c[PIX_W-1:0];
            end
        end
    end
endmodule
